// File: rtl/hps_mm_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hps_mm_bridge: Avalon-MM slave register block for multi-channel TX/RX    |
// | FIFOs, control strobes, thresholds and masked sticky interrupts.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hps_mm_bridge #(
  parameter int DATA_W       = 8,
  parameter int CHANNELS     = 2,
  parameter int LEVEL_W      = 8,
  parameter int RX_THR_RST   = 600,
  parameter int COMP_THR_RST = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   address,
  input  logic                         read_en,
  input  logic                         write_en,
  input  logic                         chipselect,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic [CHANNELS*DATA_W-1:0]   data_tx,
  output logic [CHANNELS-1:0]          wren_fifo_tx,
  input  logic [CHANNELS*LEVEL_W-1:0]  size_fifo_tx,
  input  logic [CHANNELS-1:0]          ready_tx,
  input  logic [CHANNELS*DATA_W-1:0]   data_rx,
  output logic [CHANNELS-1:0]          rden_fifo_rx,
  input  logic [CHANNELS*LEVEL_W-1:0]  size_fifo_rx,
  output logic [CHANNELS-1:0]          start_tx,
  output logic                         navig_timer_start,
  input  logic [CHANNELS-1:0]          irq_src,
  output logic                         irq,
  output logic [31:0]                  rx_threshold,
  output logic [31:0]                  comp_threshold,
  output logic [31:0]                  guard_interval,
  output logic [31:0]                  mem_addr,
  input  logic [31:0]                  end_address,
  input  logic [1:0]                   key,
  output logic [7:0]                   led
);

  localparam logic [7:0] c_ID      = 8'h00;
  localparam logic [7:0] c_CTRL    = 8'h04;
  localparam logic [7:0] c_TX_DATA = 8'h08;
  localparam logic [7:0] c_RX_DATA = 8'h0C;
  localparam logic [7:0] c_STATUS  = 8'h10;
  localparam logic [7:0] c_RX_THR  = 8'h14;
  localparam logic [7:0] c_CMP_THR = 8'h18;
  localparam logic [7:0] c_GUARD   = 8'h1C;
  localparam logic [7:0] c_MEM     = 8'h20;
  localparam logic [7:0] c_END     = 8'h24;
  localparam logic [7:0] c_IRQ_PND = 8'h28;
  localparam logic [7:0] c_IRQ_MSK = 8'h2C;
  localparam logic [7:0] c_LED     = 8'h30;

  logic [2:0]              r_sel;
  logic [7:0]              r_ovf, r_udf;
  logic [CHANNELS-1:0]     r_irq_src_q, r_irq_pend, r_irq_mask;
  logic [CHANNELS-1:0]     w_irq_rise, w_pend_clr;
  logic                    w_wr, w_rd, w_sel_ok;
  logic [7:0]              w_sel_oh, w_wsel_oh;
  logic [31:0]             w_rdata;

  // Channel views padded to 8 entries so any 3-bit sel indexes safely.
  logic [LEVEL_W-1:0]      w_size_tx_a [8];
  logic [LEVEL_W-1:0]      w_size_rx_a [8];
  logic [DATA_W-1:0]       w_data_rx_a [8];
  logic [7:0]              w_ready_a;
  logic [LEVEL_W-1:0]      w_lvl_tx, w_lvl_rx;
  logic [7:0]              w_lvl_rx8;
  logic                    w_unused;

  for (genvar g = 0; g < 8; g++) begin : g_ch
    if (g < CHANNELS) begin : g_live
      assign w_size_tx_a[g] = size_fifo_tx[g*LEVEL_W +: LEVEL_W];
      assign w_size_rx_a[g] = size_fifo_rx[g*LEVEL_W +: LEVEL_W];
      assign w_data_rx_a[g] = data_rx[g*DATA_W +: DATA_W];
      assign w_ready_a[g]   = ready_tx[g];
    end else begin : g_pad
      assign w_size_tx_a[g] = '0;
      assign w_size_rx_a[g] = '0;
      assign w_data_rx_a[g] = '0;
      assign w_ready_a[g]   = 1'b0;
    end
  end

  if (LEVEL_W >= 8) begin : g_lvl_trunc
    assign w_lvl_rx8 = w_lvl_rx[7:0];
  end else begin : g_lvl_ext
    assign w_lvl_rx8 = {{(8-LEVEL_W){1'b0}}, w_lvl_rx};
  end

  assign w_wr       = chipselect & write_en;
  assign w_rd       = chipselect & read_en & ~write_en;
  assign w_sel_ok   = 32'(r_sel) < CHANNELS;
  assign w_sel_oh   = 8'b1 << r_sel;
  assign w_wsel_oh  = 8'b1 << writedata[10:8];
  assign w_lvl_tx   = w_size_tx_a[r_sel];
  assign w_lvl_rx   = w_size_rx_a[r_sel];
  assign w_irq_rise = irq_src & ~r_irq_src_q;
  assign w_pend_clr = (w_wr && address == c_IRQ_PND) ? writedata[CHANNELS-1:0] : '0;
  assign w_unused   = key[1];

  always_comb begin
    w_rdata = '0;
    case (address)
      c_ID:      w_rdata = {16'h4842, 8'(CHANNELS), 8'(DATA_W)};
      c_CTRL:    w_rdata = {21'b0, r_sel, 8'b0};
      c_RX_DATA: if (w_sel_ok && w_lvl_rx != '0) w_rdata = 32'(w_data_rx_a[r_sel]);
      c_STATUS:  w_rdata = {r_ovf, r_udf, w_ready_a[r_sel], 7'b0, w_lvl_rx8};
      c_RX_THR:  w_rdata = rx_threshold;
      c_CMP_THR: w_rdata = comp_threshold;
      c_GUARD:   w_rdata = guard_interval;
      c_MEM:     w_rdata = mem_addr;
      c_END:     w_rdata = end_address;
      c_IRQ_PND: w_rdata = 32'(r_irq_pend);
      c_IRQ_MSK: w_rdata = 32'(r_irq_mask);
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata          <= '0;
      data_tx           <= '0;
      wren_fifo_tx      <= '0;
      rden_fifo_rx      <= '0;
      start_tx          <= '0;
      navig_timer_start <= 1'b0;
      irq               <= 1'b0;
      rx_threshold      <= 32'(RX_THR_RST);
      comp_threshold    <= 32'(COMP_THR_RST);
      guard_interval    <= '0;
      mem_addr          <= '0;
      led               <= '0;
      r_sel             <= '0;
      r_ovf             <= '0;
      r_udf             <= '0;
      r_irq_src_q       <= '0;
      r_irq_pend        <= '0;
      r_irq_mask        <= '0;
    end else begin
      wren_fifo_tx      <= '0;
      rden_fifo_rx      <= '0;
      start_tx          <= '0;
      navig_timer_start <= 1'b0;
      r_irq_src_q       <= irq_src;
      readdata          <= w_rd ? w_rdata : 32'd0;
      // A new edge wins over a same-cycle W1C clear.
      r_irq_pend        <= (r_irq_pend & ~w_pend_clr) | w_irq_rise;
      irq               <= |(r_irq_pend & r_irq_mask);

      if (w_wr) begin
        case (address)
          c_CTRL: begin
            r_sel <= writedata[10:8];
            // The start strobe targets the channel selected by this same write.
            if (writedata[0]) start_tx <= w_wsel_oh[CHANNELS-1:0];
            navig_timer_start <= writedata[1];
          end
          c_TX_DATA: begin
            if (w_sel_ok) begin
              if (!(&w_lvl_tx)) begin
                wren_fifo_tx <= w_sel_oh[CHANNELS-1:0];
                for (int i = 0; i < CHANNELS; i++)
                  if (w_sel_oh[i]) data_tx[i*DATA_W +: DATA_W] <= writedata[DATA_W-1:0];
              end else begin
                r_ovf <= r_ovf | w_sel_oh;
              end
            end
          end
          c_STATUS: begin
            r_ovf <= r_ovf & ~writedata[31:24];
            r_udf <= r_udf & ~writedata[23:16];
          end
          c_RX_THR:  rx_threshold   <= writedata;
          c_CMP_THR: comp_threshold <= writedata;
          c_GUARD:   guard_interval <= writedata;
          c_MEM:     mem_addr       <= writedata;
          c_IRQ_MSK: r_irq_mask     <= writedata[CHANNELS-1:0];
          c_LED:     led            <= writedata[7:0];
          default: ;
        endcase
      end

      if (w_rd && address == c_RX_DATA && w_sel_ok) begin
        if (w_lvl_rx != '0) rden_fifo_rx <= w_sel_oh[CHANNELS-1:0];
        else                r_udf        <= r_udf | w_sel_oh;
      end

      if (!key[0]) led[1:0] <= 2'b11;
    end
  end

endmodule
`default_nettype wire
